// File: rtl/audioqsys_pio_irq.sv
// rtl/audioqsys_pio_irq.sv - Avalon-MM PIO: set/clear output register, synchronised
// input with per-bit edge capture and maskable level interrupt.
module audioqsys_pio_irq #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] OUT_RESET   = '0,
  parameter int               EDGE_TYPE   = 0,
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_OUT    = 3'd1;
  localparam logic [2:0] ADDR_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] clr_mask;
  logic [WIDTH-1:0] edge_ev;
  logic [WIDTH-1:0] wd;
  logic [2:0]       arm_cnt_q, arm_cnt_d;
  logic             armed_q, armed_d;
  logic             wr_en;

  assign wr_en   = chipselect & ~write_n;
  assign wd      = writedata[WIDTH-1:0];
  assign in_sync = sync_q[SYNC_STAGES-1];

  generate
    if (WIDTH < 32) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[31:WIDTH];
    end
  endgenerate

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_ev = in_sync & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_ev = ~in_sync & prev_q;
    end else begin
      edge_ev = in_sync ^ prev_q;
    end
  end

  // Captures stay disabled until the synchroniser and in_prev hold real input levels.
  always_comb begin
    arm_cnt_d = arm_cnt_q;
    armed_d   = armed_q;
    if (!armed_q) begin
      if (arm_cnt_q == 3'(SYNC_STAGES)) begin
        armed_d = 1'b1;
      end else begin
        arm_cnt_d = arm_cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    clr_mask   = '0;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_out_d = wd;
        ADDR_MASK:   irq_mask_d = wd;
        ADDR_EDGE:   clr_mask   = wd;
        ADDR_OUTSET: data_out_d = data_out_q | wd;
        ADDR_OUTCLR: data_out_d = data_out_q & ~wd;
        default:     data_out_d = data_out_q;
      endcase
    end
    // A new edge wins over a simultaneous write-1-to-clear.
    edge_cap_d = (edge_cap_q & ~clr_mask) | (edge_ev & {WIDTH{armed_q}});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      prev_q     <= '0;
      data_out_q <= OUT_RESET;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      arm_cnt_q  <= '0;
      armed_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
      prev_q     <= in_sync;
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      arm_cnt_q  <= arm_cnt_d;
      armed_q    <= armed_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = in_sync;
      ADDR_OUT:  readdata[WIDTH-1:0] = data_out_q;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_cap_q;
      default:   readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule
